riscv_mc_datapath: RTL and testbench
====================================

# riscv_mc_datapath

Multi-cycle RV32 datapath, the parametrised successor of the single-cycle datapath. Instruction fetch and data access go through request/acknowledge ports, so variable-latency memories can be attached. An internal sequencer steps each instruction through FETCH/EXEC/MEM/WB. The block still takes decoded control from the existing external controller and keeps the ecall LED/halt semantics, adding a retired-instruction counter.

## Interface
Parameters:
- RESET_PC, 32'h0, PC value loaded on reset
- IMEM_AW, 10, instruction word-address width
- DMEM_AW, 10, data word-address width
- ECALL_LED_CODE, 34, a7 value that selects "display a0 on LEDs"

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- go  in  1  resume from ecall halt; level-sensitive, sampled in HALT
- ctl  in  17  decoded control bundle, valid during EXEC/MEM/WB
  - bundle fields: beq, bne, blt, mem_to_reg, mem_write, reg_write, jal, jalr, lbu, s_type, ecall, alu_src_b, alu_op[3:0], plus one spare bit
- op  out  5  IR[6:2]
- func  out  5  {IR[30],IR[25],IR[14:12]}
- ir21  out  1  IR[21]
- imem_req  out  1  fetch request
- imem_addr  out  IMEM_AW  PC[IMEM_AW+1:2]
- imem_ack  in  1  fetch data valid
- imem_rdata  in  32  instruction word
- dmem_req  out  1  data request
- dmem_we  out  1  write strobe
- dmem_addr  out  DMEM_AW  ALU result[DMEM_AW+1:2]
- dmem_wdata  out  32  rs2
- dmem_be  out  4  byte enables, always 4'hF in this revision
- dmem_ack  in  1  read data valid / write accepted
- dmem_rdata  in  32  read word
- led_data  out  32  LED register
- halted  out  1  high in HALT state
- instret  out  32  retired-instruction count

## Operation
- Sequencer states: FETCH, EXEC, MEM, WB, HALT.
- **FETCH**
  - imem_req=1 until imem_ack.
  - On the ack edge, latch IR and go to EXEC.
- **EXEC**
  - Register reads: rs1/rs2 come from IR, or x17/x10 when ctl.ecall.
  - ALU B operand: rs2 or sign-extended I/S immediate; ecall forces 32'h22.
  - Latch the ALU result and the branch target into internal registers. Target is PC+imm_B/imm_J, or (rs1+imm_I) for jalr.
  - Next state: MEM if mem_to_reg or mem_write; HALT if ecall and x17≠ECALL_LED_CODE; otherwise WB.
- **MEM**
  - dmem_req=1 (dmem_we=mem_write) until dmem_ack.
  - On ack, latch dmem_rdata and go to WB.
- **WB**
  - reg_write commits the writeback value to rd. Source priority: PC+4 for jal/jalr, then the lbu byte, then the memory word, then the ALU result.
  - lbu byte lane = result[1:0]: 0→[7:0], 1→[15:8], 2→[23:16], 3→[31:24]; zero-extended.
  - If ecall and x17==ECALL_LED_CODE, led_data←x10.
  - PC←target if (beq&eq)|(bne&~eq)|(blt&lt)|jal|jalr, else PC+4.
  - instret+1 (wraps at 2^32). Go to FETCH.
- **HALT**
  - halted=1. PC and IR are held.
  - When go=1, go to WB: PC+4 is committed, the ecall is counted, and no register write occurs.
- Writes to x0 are discarded. The existing RegFile guarantees this.

## Timing
- Zero-wait memories (ack in the same cycle as req): non-memory instruction takes 3 cycles (FETCH, EXEC, WB); load/store takes 4.
- Each wait cycle on imem_ack or dmem_ack adds exactly one cycle. The request stays high, with address and data held stable, until ack.
- Ack while the corresponding req is low is ignored.
- Reset values: PC=RESET_PC, state=FETCH, IR=0, led_data=0, instret=0, halted=0, imem_req=0 and dmem_req=0 during the reset cycle.
  - imem_req rises in the first cycle after rst deasserts.
- Reset asserted mid-fetch or mid-MEM aborts the access. The memory must drop any pending ack once req falls.
- The register file is not reset.
- go held high across HALT entry: the block exits HALT on the first HALT cycle.
- Branch target and branch condition use EXEC-cycle operands. WB does not re-read registers.

## Structure
- Package riscv_mc_pkg holds:
  - state enum
  - ctl_t packed struct (17 bits, field order as listed under Interface)
  - ALU opcode constants (add = 4'h5)
  - ECALL register indices 17 and 10
- Sub-module riscv_mc_seq holds the state register, next-state logic and req generation.
- Datapath registers and muxes stay in the top module, reusing the existing ALU and RegFile.

## Test plan
- Reset then addi x1,x0,5 with zero-wait imem → imem_req high on cycle 1; x1=5; instret=1 after 3 cycles; PC=4.
- sw x1,8(x0) then lbu x2,8(x0) with dmem_ack delayed 2 cycles → dmem_req held 3 cycles per access with stable addr=2; x2=5; each instruction takes 6 cycles.
- beq x1,x1,-4 taken and bne x1,x1 not taken → PC moves back by 4, or advances by 4, respectively.
- ecall with x17=34, x10=0xABCD → led_data=0xABCD next WB, no halt. ecall with x17=10 → halted=1, PC held; go pulse → halted=0, PC+4, instret+1.
- rst asserted during a stalled MEM → dmem_req low next cycle, PC=RESET_PC, instret=0, led_data=0.
- jal x1,+8 at PC=0x10 → x1=0x14, PC=0x18.

Source files
------------

// File: rtl/riscv_mc_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | riscv_mc_pkg                                                          |
// | Shared types and constants for the multi-cycle RV32 datapath.         |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package riscv_mc_pkg;

    localparam logic [2:0] c_ST_FETCH = 3'd0;
    localparam logic [2:0] c_ST_EXEC  = 3'd1;
    localparam logic [2:0] c_ST_MEM   = 3'd2;
    localparam logic [2:0] c_ST_WB    = 3'd3;
    localparam logic [2:0] c_ST_HALT  = 3'd4;

    typedef enum logic [2:0] {
        ST_FETCH = c_ST_FETCH,
        ST_EXEC  = c_ST_EXEC,
        ST_MEM   = c_ST_MEM,
        ST_WB    = c_ST_WB,
        ST_HALT  = c_ST_HALT
    } state_e;

    typedef struct packed {
        logic       beq;
        logic       bne;
        logic       blt;
        logic       mem_to_reg;
        logic       mem_write;
        logic       reg_write;
        logic       jal;
        logic       jalr;
        logic       lbu;
        logic       s_type;
        logic       ecall;
        logic       alu_src_b;
        logic [3:0] alu_op;
        logic       spare;
    } ctl_t;

    localparam logic [3:0] c_ALU_AND  = 4'h0;
    localparam logic [3:0] c_ALU_OR   = 4'h1;
    localparam logic [3:0] c_ALU_XOR  = 4'h2;
    localparam logic [3:0] c_ALU_SLL  = 4'h3;
    localparam logic [3:0] c_ALU_SRL  = 4'h4;
    localparam logic [3:0] c_ALU_ADD  = 4'h5;
    localparam logic [3:0] c_ALU_SUB  = 4'h6;
    localparam logic [3:0] c_ALU_SLT  = 4'h7;
    localparam logic [3:0] c_ALU_SRA  = 4'h8;
    localparam logic [3:0] c_ALU_SLTU = 4'h9;

    localparam logic [4:0] c_REG_A7 = 5'd17;
    localparam logic [4:0] c_REG_A0 = 5'd10;

    function automatic logic [31:0] alu_f(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] y;
        case (op)
            c_ALU_AND:  y = a & b;
            c_ALU_OR:   y = a | b;
            c_ALU_XOR:  y = a ^ b;
            c_ALU_SLL:  y = a << b[4:0];
            c_ALU_SRL:  y = a >> b[4:0];
            c_ALU_SUB:  y = a - b;
            c_ALU_SLT:  y = {31'd0, $signed(a) < $signed(b)};
            c_ALU_SRA:  y = $unsigned($signed(a) >>> b[4:0]);
            c_ALU_SLTU: y = {31'd0, a < b};
            default:    y = a + b;
        endcase
        return y;
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_mc_datapath_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | riscv_mc_datapath_if                                                  |
// | Instruction and data request/acknowledge memory bus.                  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
interface riscv_mc_datapath_if #(
    parameter int IMEM_AW = 10,
    parameter int DMEM_AW = 10
);
    logic               imem_req;
    logic [IMEM_AW-1:0] imem_addr;
    logic               imem_ack;
    logic [31:0]        imem_rdata;
    logic               dmem_req;
    logic               dmem_we;
    logic [DMEM_AW-1:0] dmem_addr;
    logic [31:0]        dmem_wdata;
    logic [3:0]         dmem_be;
    logic               dmem_ack;
    logic [31:0]        dmem_rdata;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output imem_ack, imem_rdata, dmem_ack, dmem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/riscv_mc_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | riscv_mc_seq                                                          |
// | FETCH/EXEC/MEM/WB/HALT sequencer with memory request generation.      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module riscv_mc_seq
    import riscv_mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_go,
    input  logic       i_imem_ack,
    input  logic       i_dmem_ack,
    input  logic       i_mem_op,
    input  logic       i_ecall,
    input  logic       i_led_hit,
    output logic [2:0] o_state,
    output logic       o_imem_req,
    output logic       o_dmem_req
);
    logic [2:0] r_state_q;
    logic [2:0] w_state_d;

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_ST_FETCH: if (i_imem_ack) w_state_d = c_ST_EXEC;
            c_ST_EXEC: begin
                if (i_mem_op)                   w_state_d = c_ST_MEM;
                else if (i_ecall && !i_led_hit) w_state_d = c_ST_HALT;
                else                            w_state_d = c_ST_WB;
            end
            c_ST_MEM:  if (i_dmem_ack) w_state_d = c_ST_WB;
            c_ST_WB:   w_state_d = c_ST_FETCH;
            c_ST_HALT: if (i_go) w_state_d = c_ST_WB;
            default:   w_state_d = c_ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state_q <= c_ST_FETCH;
        else     r_state_q <= w_state_d;
    end

    // Requests are masked while rst is high so a reset aborts any access at once.
    assign o_state    = r_state_q;
    assign o_imem_req = !rst && (r_state_q == c_ST_FETCH);
    assign o_dmem_req = !rst && (r_state_q == c_ST_MEM);
endmodule
`default_nettype wire

// File: rtl/riscv_mc_datapath.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | riscv_mc_datapath                                                     |
// | Multi-cycle RV32 datapath with req/ack memories and ecall LED/halt.   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module riscv_mc_datapath
    import riscv_mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0,
    parameter int          IMEM_AW        = 10,
    parameter int          DMEM_AW        = 10,
    parameter logic [31:0] ECALL_LED_CODE = 32'd34
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                go,
    input  ctl_t                ctl,
    output logic [4:0]          op,
    output logic [4:0]          func,
    output logic                ir21,
    riscv_mc_datapath_if.master bus,
    output logic [31:0]         led_data,
    output logic                halted,
    output logic [31:0]         instret
);
    logic [2:0]  w_state;
    logic        w_imem_req, w_dmem_req;
    logic [31:0] r_pc_q, w_pc_d, r_ir_q, w_ir_d, r_res_q, w_res_d, r_tgt_q, w_tgt_d;
    logic [31:0] r_rs2v_q, w_rs2v_d, r_mdr_q, w_mdr_d, r_led_q, w_led_d;
    logic [31:0] r_instret_q, w_instret_d;
    logic        r_eq_q, w_eq_d, r_lt_q, w_lt_d, r_led_hit_q, w_led_hit_d;
    logic [31:0] r_rf_q [32];

    logic [4:0]  w_rs1, w_rs2, w_rd;
    logic [31:0] w_rs1v, w_rs2v, w_imm_i, w_imm_s, w_imm_b, w_imm_j;
    logic [31:0] w_alu_b, w_alu_y, w_pc4, w_tgt, w_wb_val;
    logic [7:0]  w_byte;
    logic        w_led_hit, w_taken, w_rf_we, w_unused;

    riscv_mc_seq u_seq (
        .clk        (clk),
        .rst        (rst),
        .i_go       (go),
        .i_imem_ack (bus.imem_ack),
        .i_dmem_ack (bus.dmem_ack),
        .i_mem_op   (ctl.mem_to_reg | ctl.mem_write),
        .i_ecall    (ctl.ecall),
        .i_led_hit  (w_led_hit),
        .o_state    (w_state),
        .o_imem_req (w_imem_req),
        .o_dmem_req (w_dmem_req)
    );

    // ecall redirects the register reads to a7/a0 so the code and payload are visible.
    assign w_rs1  = ctl.ecall ? c_REG_A7 : r_ir_q[19:15];
    assign w_rs2  = ctl.ecall ? c_REG_A0 : r_ir_q[24:20];
    assign w_rd   = r_ir_q[11:7];
    assign w_rs1v = (w_rs1 == 5'd0) ? 32'd0 : r_rf_q[w_rs1];
    assign w_rs2v = (w_rs2 == 5'd0) ? 32'd0 : r_rf_q[w_rs2];

    assign w_imm_i = {{20{r_ir_q[31]}}, r_ir_q[31:20]};
    assign w_imm_s = {{20{r_ir_q[31]}}, r_ir_q[31:25], r_ir_q[11:7]};
    assign w_imm_b = {{19{r_ir_q[31]}}, r_ir_q[31], r_ir_q[7], r_ir_q[30:25], r_ir_q[11:8], 1'b0};
    assign w_imm_j = {{11{r_ir_q[31]}}, r_ir_q[31], r_ir_q[19:12], r_ir_q[20], r_ir_q[30:21], 1'b0};

    assign w_alu_b   = ctl.ecall ? 32'h22 : (!ctl.alu_src_b ? w_rs2v : (ctl.s_type ? w_imm_s : w_imm_i));
    assign w_alu_y   = alu_f(ctl.alu_op, w_rs1v, w_alu_b);
    assign w_pc4     = r_pc_q + 32'd4;
    assign w_tgt     = ctl.jalr ? (w_rs1v + w_imm_i) : (r_pc_q + (ctl.jal ? w_imm_j : w_imm_b));
    assign w_led_hit = ctl.ecall && (w_rs1v == ECALL_LED_CODE);
    assign w_taken   = (ctl.beq & r_eq_q) | (ctl.bne & ~r_eq_q) | (ctl.blt & r_lt_q) | ctl.jal | ctl.jalr;
    assign w_byte    = r_mdr_q[{r_res_q[1:0], 3'b000} +: 8];
    assign w_wb_val  = (ctl.jal | ctl.jalr) ? w_pc4 :
                       ctl.lbu              ? {24'd0, w_byte} :
                       ctl.mem_to_reg       ? r_mdr_q : r_res_q;
    // A resumed ecall passes through WB but must never write the register file.
    assign w_rf_we   = (w_state == c_ST_WB) && ctl.reg_write && !ctl.ecall && (w_rd != 5'd0);

    always_comb begin
        w_pc_d      = r_pc_q;
        w_ir_d      = r_ir_q;
        w_res_d     = r_res_q;
        w_tgt_d     = r_tgt_q;
        w_eq_d      = r_eq_q;
        w_lt_d      = r_lt_q;
        w_rs2v_d    = r_rs2v_q;
        w_led_hit_d = r_led_hit_q;
        w_mdr_d     = r_mdr_q;
        w_led_d     = r_led_q;
        w_instret_d = r_instret_q;
        case (w_state)
            c_ST_FETCH: if (bus.imem_ack) w_ir_d = bus.imem_rdata;
            c_ST_EXEC: begin
                w_res_d     = w_alu_y;
                w_tgt_d     = w_tgt;
                w_eq_d      = (w_rs1v == w_rs2v);
                w_lt_d      = ($signed(w_rs1v) < $signed(w_rs2v));
                w_rs2v_d    = w_rs2v;
                w_led_hit_d = w_led_hit;
            end
            c_ST_MEM: if (bus.dmem_ack) w_mdr_d = bus.dmem_rdata;
            c_ST_WB: begin
                w_pc_d      = w_taken ? r_tgt_q : w_pc4;
                w_instret_d = r_instret_q + 32'd1;
                if (r_led_hit_q) w_led_d = r_rs2v_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_q      <= RESET_PC;
            r_ir_q      <= 32'd0;
            r_res_q     <= 32'd0;
            r_tgt_q     <= 32'd0;
            r_eq_q      <= 1'b0;
            r_lt_q      <= 1'b0;
            r_rs2v_q    <= 32'd0;
            r_led_hit_q <= 1'b0;
            r_mdr_q     <= 32'd0;
            r_led_q     <= 32'd0;
            r_instret_q <= 32'd0;
        end else begin
            r_pc_q      <= w_pc_d;
            r_ir_q      <= w_ir_d;
            r_res_q     <= w_res_d;
            r_tgt_q     <= w_tgt_d;
            r_eq_q      <= w_eq_d;
            r_lt_q      <= w_lt_d;
            r_rs2v_q    <= w_rs2v_d;
            r_led_hit_q <= w_led_hit_d;
            r_mdr_q     <= w_mdr_d;
            r_led_q     <= w_led_d;
            r_instret_q <= w_instret_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_rf_we) r_rf_q[w_rd] <= w_wb_val;
    end

    assign op       = r_ir_q[6:2];
    assign func     = {r_ir_q[30], r_ir_q[25], r_ir_q[14:12]};
    assign ir21     = r_ir_q[21];
    assign led_data = r_led_q;
    assign halted   = !rst && (w_state == c_ST_HALT);
    assign instret  = r_instret_q;

    assign bus.imem_req   = w_imem_req;
    assign bus.imem_addr  = r_pc_q[IMEM_AW+1:2];
    assign bus.dmem_req   = w_dmem_req;
    assign bus.dmem_we    = w_dmem_req & ctl.mem_write;
    assign bus.dmem_addr  = r_res_q[DMEM_AW+1:2];
    assign bus.dmem_wdata = r_rs2v_q;
    assign bus.dmem_be    = 4'hF;

    assign w_unused = ^{ctl.spare, r_ir_q[1:0]};
endmodule
`default_nettype wire

// File: tb/tb_riscv_mc_datapath.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------+
// | tb_riscv_mc_datapath                                                  |
// | Directed program bench with req/ack memory models and a decoder.      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_riscv_mc_datapath;
    import riscv_mc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go  = 1'b0;
    ctl_t        ctl;
    logic [4:0]  op, func;
    logic        ir21;
    logic [31:0] led_data, instret;
    logic        halted;

    int n_checks = 0;
    int n_err    = 0;
    int iw = 0;
    int dw = 0;
    int icnt, dcnt;

    logic [31:0] imem [1024];
    logic [31:0] dmem [1024];

    riscv_mc_datapath_if bus ();

    riscv_mc_datapath dut (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .ctl      (ctl),
        .op       (op),
        .func     (func),
        .ir21     (ir21),
        .bus      (bus),
        .led_data (led_data),
        .halted   (halted),
        .instret  (instret)
    );

    always #5 clk = ~clk;

    // Memory models: ack after a programmable number of wait cycles, only while req is high.
    assign bus.imem_ack   = bus.imem_req && (icnt >= iw);
    assign bus.imem_rdata = imem[bus.imem_addr];
    assign bus.dmem_ack   = bus.dmem_req && (dcnt >= dw);
    assign bus.dmem_rdata = dmem[bus.dmem_addr];

    always @(posedge clk) begin
        icnt <= (bus.imem_req && !bus.imem_ack) ? icnt + 1 : 0;
        dcnt <= (bus.dmem_req && !bus.dmem_ack) ? dcnt + 1 : 0;
        if (rst) begin
            for (int k = 0; k < 1024; k++)
                dmem[k] <= (k == 3) ? 32'h1122_3344 : (k == 5) ? 32'h0000_ABCD : 32'd0;
        end else if (bus.dmem_req && bus.dmem_we && bus.dmem_ack) begin
            dmem[bus.dmem_addr] <= bus.dmem_wdata;
        end
    end

    // Stand-in for the external controller.
    function automatic ctl_t decode(input logic [4:0] o, input logic [4:0] f);
        ctl_t c;
        c = '0;
        c.alu_op = c_ALU_ADD;
        case (o)
            5'b00100: begin c.reg_write = 1'b1; c.alu_src_b = 1'b1; end
            5'b01100: begin c.reg_write = 1'b1; if (f[4]) c.alu_op = c_ALU_SUB; end
            5'b00000: begin
                c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.alu_src_b = 1'b1;
                c.lbu = (f[2:0] == 3'b100);
            end
            5'b01000: begin c.mem_write = 1'b1; c.alu_src_b = 1'b1; c.s_type = 1'b1; end
            5'b11000: begin
                c.alu_op = c_ALU_SUB;
                c.beq = (f[2:0] == 3'b000);
                c.bne = (f[2:0] == 3'b001);
                c.blt = (f[2:0] == 3'b100);
            end
            5'b11011: begin c.jal = 1'b1; c.reg_write = 1'b1; end
            5'b11001: begin c.jalr = 1'b1; c.reg_write = 1'b1; c.alu_src_b = 1'b1; end
            5'b11100: c.ecall = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    always_comb ctl = decode(op, func);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        int          iw;
        int          dw;
        int          cyc;
        logic [31:0] npc;
        logic [31:0] led;
        int          dreq;
        logic [9:0]  daddr;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int i);
        vec_t        v;
        int          n, nd;
        logic [31:0] start;
        v = vecs[i];
        iw = v.iw;
        dw = v.dw;
        start = instret;
        n = 0;
        nd = 0;
        do begin
            step();
            n++;
            if (bus.dmem_req) begin
                nd++;
                chk($sformatf("v%0d_daddr", i), 32'(bus.dmem_addr), 32'(v.daddr));
                chk($sformatf("v%0d_dwe", i), 32'(bus.dmem_we), 32'(v.instr[6:2] == 5'b01000));
                chk($sformatf("v%0d_dbe", i), 32'(bus.dmem_be), 32'h0000000F);
            end
        end while (instret == start && n < 40);
        chk($sformatf("v%0d_cycles", i), 32'(n), 32'(v.cyc));
        chk($sformatf("v%0d_instret", i), instret, 32'(i + 1));
        chk($sformatf("v%0d_pc", i), 32'(bus.imem_addr), v.npc >> 2);
        chk($sformatf("v%0d_led", i), led_data, v.led);
        chk($sformatf("v%0d_dreq_cycles", i), 32'(nd), 32'(v.dreq));
        chk($sformatf("v%0d_op", i), 32'(op), 32'(v.instr[6:2]));
        chk($sformatf("v%0d_ir21", i), 32'(ir21), 32'(v.instr[21]));
    endtask

    initial begin
        //           pc        instr          iw dw cyc npc       led           dreq daddr
        vecs[0]  = '{32'h00, 32'h0050_0093, 0, 0, 3, 32'h04, 32'h0,      0, 10'd0}; // addi x1,x0,5
        vecs[1]  = '{32'h04, 32'h0010_2423, 0, 2, 6, 32'h08, 32'h0,      3, 10'd2}; // sw x1,8(x0)
        vecs[2]  = '{32'h08, 32'h0080_4103, 0, 2, 6, 32'h0C, 32'h0,      3, 10'd2}; // lbu x2,8(x0)
        vecs[3]  = '{32'h0C, 32'h0220_0893, 1, 0, 4, 32'h10, 32'h0,      0, 10'd0}; // addi x17,x0,34
        vecs[4]  = '{32'h10, 32'h0080_00EF, 0, 0, 3, 32'h18, 32'h0,      0, 10'd0}; // jal x1,+8
        vecs[5]  = '{32'h18, 32'h0001_0513, 0, 0, 3, 32'h1C, 32'h0,      0, 10'd0}; // addi x10,x2,0
        vecs[6]  = '{32'h1C, 32'h0000_0073, 0, 0, 3, 32'h20, 32'h5,      0, 10'd0}; // ecall
        vecs[7]  = '{32'h20, 32'h0000_8513, 0, 0, 3, 32'h24, 32'h5,      0, 10'd0}; // addi x10,x1,0
        vecs[8]  = '{32'h24, 32'h0000_0073, 0, 0, 3, 32'h28, 32'h14,     0, 10'd0}; // ecall
        vecs[9]  = '{32'h28, 32'h00D0_4503, 0, 0, 4, 32'h2C, 32'h14,     1, 10'd3}; // lbu x10,13(x0)
        vecs[10] = '{32'h2C, 32'h0000_0073, 0, 0, 3, 32'h30, 32'h33,     0, 10'd0}; // ecall
        vecs[11] = '{32'h30, 32'h0140_2503, 0, 1, 5, 32'h34, 32'h33,     2, 10'd5}; // lw x10,20(x0)
        vecs[12] = '{32'h34, 32'h0000_0073, 0, 0, 3, 32'h38, 32'hABCD,   0, 10'd0}; // ecall
        vecs[13] = '{32'h38, 32'h0080_006F, 0, 0, 3, 32'h40, 32'hABCD,   0, 10'd0}; // jal x0,+8
        vecs[14] = '{32'h40, 32'hFE10_8EE3, 0, 0, 3, 32'h3C, 32'hABCD,   0, 10'd0}; // beq x1,x1,-4
        vecs[15] = '{32'h3C, 32'h0080_006F, 0, 0, 3, 32'h44, 32'hABCD,   0, 10'd0}; // jal x0,+8
        vecs[16] = '{32'h44, 32'h0010_9463, 0, 0, 3, 32'h48, 32'hABCD,   0, 10'd0}; // bne x1,x1,+8
        vecs[17] = '{32'h48, 32'h00F0_4503, 0, 0, 4, 32'h4C, 32'hABCD,   1, 10'd3}; // lbu x10,15(x0)
        vecs[18] = '{32'h4C, 32'h0000_0073, 0, 0, 3, 32'h50, 32'h11,     0, 10'd0}; // ecall
        vecs[19] = '{32'h50, 32'h00A0_0893, 0, 0, 3, 32'h54, 32'h11,     0, 10'd0}; // addi x17,x0,10

        for (int k = 0; k < 1024; k++) imem[k] = 32'h0000_0013;
        for (int k = 0; k < 20; k++) imem[vecs[k].pc[11:2]] = vecs[k].instr;
        imem[32'h54 >> 2] = 32'h0000_0073; // ecall, halts (a7=10)
        imem[32'h58 >> 2] = 32'h0140_2303; // lw x6,20(x0)

        repeat (3) step();
        chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
        chk("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_instret", instret, 32'd0);
        chk("rst_led", led_data, 32'd0);
        chk("rst_pc", 32'(bus.imem_addr), 32'd0);
        chk("rst_ir", 32'(op), 32'd0);
        rst = 1'b0;
        #1;
        chk("cycle1_imem_req", 32'(bus.imem_req), 32'd1);

        for (int i = 0; i < 20; i++) begin
            run_vec(i);
            if (i == 1) chk("sw_mem_word", dmem[2], 32'd5);
        end

        // ecall with a7=10 halts; go resumes without a register write.
        iw = 0;
        dw = 0;
        repeat (2) step();
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_pc", 32'(bus.imem_addr), 32'h15);
        chk("halt_instret", instret, 32'd20);
        repeat (3) step();
        chk("halt_hold", 32'(halted), 32'd1);
        chk("halt_pc_held", 32'(bus.imem_addr), 32'h15);
        chk("halt_no_fetch", 32'(bus.imem_req), 32'd0);
        go = 1'b1;
        step();
        go = 1'b0;
        chk("resume_halted", 32'(halted), 32'd0);
        step();
        chk("resume_instret", instret, 32'd21);
        chk("resume_pc", 32'(bus.imem_addr), 32'h16);
        chk("resume_led", led_data, 32'h11);

        // Reset during a stalled load aborts the access.
        dw = 100;
        repeat (4) step();
        chk("stall_dmem_req", 32'(bus.dmem_req), 32'd1);
        chk("stall_daddr", 32'(bus.dmem_addr), 32'd5);
        rst = 1'b1;
        #1;
        chk("rstcyc_dmem_req", 32'(bus.dmem_req), 32'd0);
        step();
        chk("abort_dmem_req", 32'(bus.dmem_req), 32'd0);
        chk("abort_pc", 32'(bus.imem_addr), 32'd0);
        chk("abort_instret", instret, 32'd0);
        chk("abort_led", led_data, 32'd0);
        chk("abort_halted", 32'(halted), 32'd0);
        rst = 1'b0;
        dw = 0;
        #1;
        chk("restart_imem_req", 32'(bus.imem_req), 32'd1);
        run_vec(0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
